// File: rtl/case_value_encoder_pkg.sv
// Shared constants and types for the case-value re-encoder.
// The optional CASE_VALUE_ENCODER_STATS_EN build adds miss/dup statistics in the top.
package case_enc_pkg;

    localparam logic [7:0] VAL_A   = 8'h00;
    localparam logic [7:0] VAL_B   = 8'h11;
    localparam logic [7:0] VAL_DUP = 8'h22;
    localparam logic [7:0] VAL_DEF = 8'hFF;

    localparam logic [1:0] SEL_A    = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic [1:0] SEL_DEF  = 2'b10;
    localparam logic [1:0] SEL_MISS = 2'b11;

    typedef logic [0:0] state_t;
    localparam state_t RUN  = 1'b0;
    localparam state_t HALT = 1'b1;

    typedef struct packed {
        logic [1:0] sel;
        logic       hit;
        logic       dup;
    } enc_t;

    localparam int unsigned ENC_W = $bits(enc_t);

endpackage

// File: rtl/case_value_encoder_fifo.sv
// Generic synchronous FIFO with occupancy count; DEPTH must be a power of two >= 2.
module case_enc_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/case_value_encoder.sv
// Re-encodes decoded 8-bit case values to their 2-bit selector, flagging shadowed and default arms.
// Define CASE_VALUE_ENCODER_STATS_EN to add saturating miss_cnt / dup_cnt statistics ports.
module case_value_encoder
    import case_enc_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter bit          STOP_ON_MISS = 1'b0
`ifdef CASE_VALUE_ENCODER_STATS_EN
    ,
    parameter int unsigned CNT_W        = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_sel,
    output logic             out_hit,
    output logic             out_dup,
    output logic             halted,
    input  logic             clr
`ifdef CASE_VALUE_ENCODER_STATS_EN
    ,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] dup_cnt
`endif
);

    // First match wins, mirroring the decoder's case priority; X/Z falls to the default arm.
    function automatic enc_t encode(input logic [7:0] v);
        enc_t r;
        r.sel = SEL_MISS;
        r.hit = 1'b0;
        r.dup = 1'b0;
        case (v)
            VAL_A:   begin r.sel = SEL_A; r.hit = 1'b1; end
            VAL_B:   begin r.sel = SEL_B; r.hit = 1'b1; end
            VAL_DUP: begin r.sel = SEL_B; r.dup = 1'b1; end
            VAL_DEF: r.sel = SEL_DEF;
            default: r.sel = SEL_MISS;
        endcase
        return r;
    endfunction

    state_t                     state;
    state_t                     state_nxt;
    enc_t                       enc;
    enc_t                       head;
    logic                       accept;
    logic                       pop;
    logic                       miss;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;

    assign enc       = encode(in_data);
    assign miss      = (enc.sel == SEL_MISS);
    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;
    assign in_ready  = ~rst & (state == RUN) & (~fifo_full | pop);
    assign accept    = in_valid & in_ready;
    assign halted    = (state == HALT);

    assign out_sel = out_valid ? head.sel : 2'b00;
    assign out_hit = out_valid & head.hit;
    assign out_dup = out_valid & head.dup;

    case_enc_fifo #(
        .WIDTH (ENC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .wdata (enc),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (unused_fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // Halt is decided on the accepted value, so a same-cycle clr cannot cancel it.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (accept && miss && STOP_ON_MISS) state_nxt = HALT;
            HALT:    if (clr) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

`ifdef CASE_VALUE_ENCODER_STATS_EN
    // Saturating statistics; clr clears them regardless of FSM state.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            miss_cnt <= '0;
            dup_cnt  <= '0;
        end else begin
            if (accept && miss && (miss_cnt != '1))    miss_cnt <= miss_cnt + CNT_W'(1);
            if (accept && enc.dup && (dup_cnt != '1))  dup_cnt  <= dup_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
